// File: rtl/decodificador_pkg.sv
// Shared types and helpers for the parametrised registered decoder.
// Mode encoding and a one-hot helper sized for the largest legal select width.
package decodificador_pkg;

    typedef enum logic [1:0] {
        DIRECT    = 2'b00,
        SCAN_UP   = 2'b01,
        SCAN_DOWN = 2'b10,
        HOLD      = 2'b11
    } mode_t;

    localparam int unsigned MAX_N = 6;

    // Callers narrow the result to their own 2^N width with a cast.
    function automatic logic [2**MAX_N-1:0] onehot(input logic [MAX_N-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/contador_barrido.sv
// Scan divider plus up/down index counter with load, freeze and wrap detection.
// Registers idx and div; exposes the next index and wrap so the top can register Q coherently.
module contador_barrido #(
    parameter int unsigned N        = 3,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         hold,
    input  logic         load,
    input  logic         clear_div,
    input  logic         down,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] idx,
    output logic [N-1:0] idx_next,
    output logic         wrap_next
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div;
    logic [DW-1:0] div_next;

    // Priority: disable freezes, then load, then mode-change clear, then hold, then step.
    always_comb begin
        idx_next  = idx;
        div_next  = div;
        wrap_next = 1'b0;
        if (!en) begin
            idx_next = idx;
        end else if (load) begin
            idx_next = load_val;
            div_next = '0;
        end else if (clear_div) begin
            div_next = '0;
        end else if (!hold) begin
            if (div == DIV_LAST) begin
                div_next = '0;
                if (down) begin
                    idx_next  = idx - 1'b1;
                    wrap_next = (idx == '0);
                end else begin
                    idx_next  = idx + 1'b1;
                    wrap_next = (idx == '1);
                end
            end else begin
                div_next = div + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            div <= '0;
        end else begin
            idx <= idx_next;
            div <= div_next;
        end
    end

endmodule

// File: rtl/decodificador_param.sv
// Registered N-to-2^N decoder with direct, scan-up, scan-down and hold modes.
// Q is built from the counter's next index so Q and idx always change on the same edge.
module decodificador_param
    import decodificador_pkg::*;
#(
    parameter int unsigned N          = 3,
    parameter int unsigned SCAN_DIV   = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    D,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic            load,
    output logic [2**N-1:0] Q,
    output logic [N-1:0]    idx,
    output logic            valid,
    output logic            wrap
);

    localparam int unsigned W = 2**N;
    localparam logic [W-1:0] Q_IDLE = {W{ACTIVE_LOW}};

    mode_t        mode_cur;
    mode_t        prev_mode;
    logic         is_scan;
    logic         cnt_load;
    logic [N-1:0] idx_next;
    logic         wrap_next;
    logic [W-1:0] oh;
    logic [W-1:0] q_next;

    always_comb begin
        mode_cur = mode_t'(mode);
        is_scan  = (mode_cur == SCAN_UP) || (mode_cur == SCAN_DOWN);
        // Direct decode reuses the counter's load path: idx<=D and div<=0.
        cnt_load = (mode_cur == DIRECT) || (is_scan && load);
    end

    contador_barrido #(
        .N        (N),
        .SCAN_DIV (SCAN_DIV)
    ) u_contador (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .hold      (mode_cur == HOLD),
        .load      (cnt_load),
        .clear_div (mode_cur != prev_mode),
        .down      (mode_cur == SCAN_DOWN),
        .load_val  (D),
        .idx       (idx),
        .idx_next  (idx_next),
        .wrap_next (wrap_next)
    );

    always_comb begin
        oh     = W'(onehot(MAX_N'(idx_next)));
        q_next = ACTIVE_LOW ? ~oh : oh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q         <= Q_IDLE;
            valid     <= 1'b0;
            wrap      <= 1'b0;
            prev_mode <= DIRECT;
        end else begin
            Q     <= en ? q_next : Q_IDLE;
            valid <= en;
            wrap  <= wrap_next;
            if (en) begin
                prev_mode <= mode_cur;
            end
        end
    end

endmodule

// File: tb/tb_decodificador_param.sv
// Directed bench for decodificador_param: three instances cover the default, SCAN_DIV=1
// and active-low N=2 configurations.
module tb_decodificador_param;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // u0: N=3, SCAN_DIV=4, active-high
    logic [2:0] d0;
    logic       en0, load0;
    logic [1:0] mode0;
    logic [7:0] q0;
    logic [2:0] idx0;
    logic       valid0, wrap0;

    // u1: N=3, SCAN_DIV=1, active-high
    logic [2:0] d1;
    logic       en1, load1;
    logic [1:0] mode1;
    logic [7:0] q1;
    logic [2:0] idx1;
    logic       valid1, wrap1;

    // u2: N=2, SCAN_DIV=2, active-low
    logic [1:0] d2;
    logic       en2, load2;
    logic [1:0] mode2;
    logic [3:0] q2;
    logic [1:0] idx2;
    logic       valid2, wrap2;

    decodificador_param #(.N(3), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .D(d0), .en(en0), .mode(mode0), .load(load0),
        .Q(q0), .idx(idx0), .valid(valid0), .wrap(wrap0));

    decodificador_param #(.N(3), .SCAN_DIV(1), .ACTIVE_LOW(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .D(d1), .en(en1), .mode(mode1), .load(load1),
        .Q(q1), .idx(idx1), .valid(valid1), .wrap(wrap1));

    decodificador_param #(.N(2), .SCAN_DIV(2), .ACTIVE_LOW(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .D(d2), .en(en2), .mode(mode2), .load(load2),
        .Q(q2), .idx(idx2), .valid(valid2), .wrap(wrap2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d0 = '0; en0 = 1'b0; load0 = 1'b0; mode0 = 2'b00;
        d1 = '0; en1 = 1'b0; load1 = 1'b0; mode1 = 2'b00;
        d2 = '0; en2 = 1'b0; load2 = 1'b0; mode2 = 2'b00;
        #12;
        checks++;
        if (q0 !== 8'h00 || idx0 !== 3'd0 || valid0 !== 1'b0 || wrap0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_u0 got Q=%h idx=%0d valid=%b wrap=%b want Q=00 idx=0 valid=0 wrap=0",
                     q0, idx0, valid0, wrap0);
        end
        checks++;
        if (q2 !== 4'hF || idx2 !== 2'd0 || valid2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_u2_active_low got Q=%h idx=%0d valid=%b want Q=f idx=0 valid=0",
                     q2, idx2, valid2);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_direct();
        logic [7:0] exp_q;
        en0 = 1'b1; mode0 = 2'b00;
        for (int i = 0; i < 8; i++) begin
            d0 = 3'(i);
            step();
            exp_q = 8'h01 << i;
            checks++;
            if (q0 !== exp_q || valid0 !== 1'b1 || idx0 !== 3'(i) || wrap0 !== 1'b0) begin
                failures++;
                $display("FAIL direct_d%0d got Q=%h idx=%0d valid=%b wrap=%b want Q=%h idx=%0d valid=1 wrap=0",
                         i, q0, idx0, valid0, wrap0, exp_q, i);
            end
        end
    endtask

    task automatic test_enable();
        d0 = 3'b101;
        step();
        checks++;
        if (q0 !== 8'h20) begin
            failures++;
            $display("FAIL enable_pre got Q=%h want 20", q0);
        end
        en0 = 1'b0;
        step();
        checks++;
        if (q0 !== 8'h00 || valid0 !== 1'b0 || idx0 !== 3'd5) begin
            failures++;
            $display("FAIL enable_off got Q=%h valid=%b idx=%0d want Q=00 valid=0 idx=5", q0, valid0, idx0);
        end
        en0 = 1'b1;
        step();
        checks++;
        if (q0 !== 8'h20 || valid0 !== 1'b1) begin
            failures++;
            $display("FAIL enable_on got Q=%h valid=%b want Q=20 valid=1", q0, valid0);
        end
    endtask

    task automatic test_scan_up();
        mode0 = 2'b01; load0 = 1'b1; d0 = 3'd6;
        step();
        load0 = 1'b0;
        // Expected Q over the 9 cycles starting with the load edge.
        for (int c = 0; c < 9; c++) begin
            logic [7:0] exp_q;
            logic       exp_w;
            if (c > 0) step();
            exp_q = (c < 4) ? 8'h40 : (c < 8) ? 8'h80 : 8'h01;
            exp_w = (c == 8);
            checks++;
            if (q0 !== exp_q || wrap0 !== exp_w || valid0 !== 1'b1) begin
                failures++;
                $display("FAIL scan_up_c%0d got Q=%h wrap=%b valid=%b want Q=%h wrap=%b valid=1",
                         c, q0, wrap0, valid0, exp_q, exp_w);
            end
        end
    endtask

    task automatic test_load_and_hold();
        // After the wrap edge div=0; three more edges bring div to its terminal count.
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (q0 !== 8'h01 || wrap0 !== 1'b0) begin
                failures++;
                $display("FAIL post_wrap_c%0d got Q=%h wrap=%b want Q=01 wrap=0", c, q0, wrap0);
            end
        end
        load0 = 1'b1; d0 = 3'd3;
        step();
        load0 = 1'b0;
        checks++;
        if (idx0 !== 3'd3 || q0 !== 8'h08 || wrap0 !== 1'b0) begin
            failures++;
            $display("FAIL load_on_terminal got idx=%0d Q=%h wrap=%b want idx=3 Q=08 wrap=0", idx0, q0, wrap0);
        end
        mode0 = 2'b11;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (q0 !== 8'h08 || idx0 !== 3'd3 || valid0 !== 1'b1 || wrap0 !== 1'b0) begin
                failures++;
                $display("FAIL hold_c%0d got Q=%h idx=%0d valid=%b wrap=%b want Q=08 idx=3 valid=1 wrap=0",
                         c, q0, idx0, valid0, wrap0);
            end
        end
    endtask

    task automatic test_scan_down_div1();
        logic [7:0] exp_q [4];
        logic       exp_w [4];
        exp_q = '{8'h02, 8'h01, 8'h80, 8'h40};
        exp_w = '{1'b0, 1'b0, 1'b1, 1'b0};
        en1 = 1'b1; mode1 = 2'b10; load1 = 1'b1; d1 = 3'd1;
        for (int c = 0; c < 4; c++) begin
            step();
            load1 = 1'b0;
            checks++;
            if (q1 !== exp_q[c] || wrap1 !== exp_w[c]) begin
                failures++;
                $display("FAIL scan_down_c%0d got Q=%h wrap=%b want Q=%h wrap=%b",
                         c, q1, wrap1, exp_q[c], exp_w[c]);
            end
        end
    endtask

    task automatic test_active_low();
        en2 = 1'b1; mode2 = 2'b00; d2 = 2'd2;
        step();
        checks++;
        if (q2 !== 4'b1011 || valid2 !== 1'b1) begin
            failures++;
            $display("FAIL al_direct got Q=%b valid=%b want Q=1011 valid=1", q2, valid2);
        end
        // Mode change edge holds idx=2, then div 0->1, then step to 3.
        mode2 = 2'b01;
        step();
        step();
        step();
        checks++;
        if (q2 !== 4'b0111 || idx2 !== 2'd3) begin
            failures++;
            $display("FAIL al_scan got Q=%b idx=%0d want Q=0111 idx=3", q2, idx2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (q2 !== 4'hF || valid2 !== 1'b0 || idx2 !== 2'd0) begin
            failures++;
            $display("FAIL al_async_reset got Q=%b valid=%b idx=%0d want Q=1111 valid=0 idx=0", q2, valid2, idx2);
        end
        checks++;
        if (q0 !== 8'h00 || idx0 !== 3'd0 || valid0 !== 1'b0) begin
            failures++;
            $display("FAIL u0_async_reset got Q=%h idx=%0d valid=%b want Q=00 idx=0 valid=0", q0, idx0, valid0);
        end
        #3;
        rst_n = 1'b1;
        // First edge after reset sees SCAN_UP vs prev DIRECT: clear div, no step.
        step();
        checks++;
        if (q2 !== 4'b1110 || idx2 !== 2'd0 || valid2 !== 1'b1) begin
            failures++;
            $display("FAIL al_after_reset got Q=%b idx=%0d valid=%b want Q=1110 idx=0 valid=1", q2, idx2, valid2);
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_enable();
        test_scan_up();
        test_load_and_hold();
        test_scan_down_div1();
        test_active_low();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
